// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Holds the FSM state encoding, owner ids and the response-error encoding.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } ArbState;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // A disabled timeout (0) still needs a one-bit timer to keep the RTL legal.
    function automatic int timerWidth(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and shared-memory handshake signals around the arbiter.
// The master modport is the arbiter's view; slave is the view of its surroundings.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [AW-1:0]   ifu_addr;
    logic            ifu_resp_valid;
    logic            ifu_resp_ready;
    logic [DW-1:0]   ifu_rdata;
    logic            ifu_resp_err;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [AW-1:0]   lsu_addr;
    logic            lsu_we;
    logic [DW-1:0]   lsu_wdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            lsu_resp_valid;
    logic            lsu_resp_ready;
    logic [DW-1:0]   lsu_rdata;
    logic            lsu_resp_err;

    logic            s_req_valid;
    logic            s_req_ready;
    logic [AW-1:0]   s_addr;
    logic            s_we;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wmask;
    logic            s_resp_valid;
    logic            s_resp_ready;
    logic [DW-1:0]   s_rdata;
    logic            s_resp_err;

    modport master (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask, lsu_resp_ready,
        input  s_req_ready, s_resp_valid, s_rdata, s_resp_err,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output s_req_valid, s_addr, s_we, s_wdata, s_wmask, s_resp_ready
    );

    modport slave (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask, lsu_resp_ready,
        output s_req_ready, s_resp_valid, s_rdata, s_resp_err,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  s_req_valid, s_addr, s_we, s_wdata, s_wmask, s_resp_ready
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// requester that was not granted last (last: 0 = req[0], 1 = req[1]).
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one valid/ready memory port between the IFU and the LSU, one
// transaction at a time, with a per-phase timeout that turns a stuck slave into an error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int TW = timerWidth(TIMEOUT);
    localparam int MW = DW / 8;

    ArbState         state;
    ArbState         stateNext;
    logic            owner;
    logic            lastGrant;
    logic [TW-1:0]   timer;
    logic [AW-1:0]   holdAddr;
    logic            holdWe;
    logic [DW-1:0]   holdWdata;
    logic [MW-1:0]   holdWmask;

    logic [1:0]      gnt;
    logic            winner;
    logic            latchReq;
    logic            timerClear;
    logic            timerExpired;

    // Bit 0 is the IFU and bit 1 the LSU, matching the OWNER_* encoding.
    rr_pick2 picker (
        .req  ({bus.lsu_req_valid, bus.ifu_req_valid}),
        .last (lastGrant),
        .gnt  (gnt)
    );

    assign winner       = gnt[1] ? OWNER_LSU : OWNER_IFU;
    assign timerExpired = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

    // State and holding registers; the IFU never writes, so its we/wdata/wmask are zeroed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWNER_IFU;
            lastGrant <= OWNER_LSU;
            timer     <= '0;
            holdAddr  <= '0;
            holdWe    <= 1'b0;
            holdWdata <= '0;
            holdWmask <= '0;
        end else begin
            state <= stateNext;
            if (latchReq) begin
                owner     <= winner;
                lastGrant <= winner;
                holdAddr  <= (winner == OWNER_LSU) ? bus.lsu_addr : bus.ifu_addr;
                holdWe    <= (winner == OWNER_LSU) && bus.lsu_we;
                holdWdata <= (winner == OWNER_LSU) ? bus.lsu_wdata : '0;
                holdWmask <= (winner == OWNER_LSU) ? bus.lsu_wmask : '0;
            end
            if (latchReq || timerClear) begin
                timer <= '0;
            end else if ((state == REQ || state == RESP) && (timer != '1)) begin
                timer <= timer + TW'(1);
            end
        end
    end

    // Next state and all handshake outputs; request readiness is held low while in reset.
    always_comb begin
        stateNext          = state;
        latchReq           = 1'b0;
        timerClear         = 1'b0;

        bus.ifu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.ifu_rdata      = '0;
        bus.ifu_resp_err   = RESP_OK;
        bus.lsu_req_ready  = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        bus.lsu_rdata      = '0;
        bus.lsu_resp_err   = RESP_OK;
        bus.s_req_valid    = 1'b0;
        bus.s_resp_ready   = 1'b0;
        bus.s_addr         = holdAddr;
        bus.s_we           = holdWe;
        bus.s_wdata        = holdWdata;
        bus.s_wmask        = holdWmask;

        unique case (state)
            IDLE: begin
                bus.ifu_req_ready = rst && gnt[0];
                bus.lsu_req_ready = rst && gnt[1];
                if (gnt != 2'b00) begin
                    latchReq  = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                bus.s_req_valid = 1'b1;
                if (bus.s_req_ready) begin
                    timerClear = 1'b1;
                    stateNext  = RESP;
                end else if (timerExpired) begin
                    stateNext = ERR;
                end
            end
            RESP: begin
                if (owner == OWNER_LSU) begin
                    bus.s_resp_ready   = bus.lsu_resp_ready;
                    bus.lsu_resp_valid = bus.s_resp_valid;
                    bus.lsu_rdata      = bus.s_rdata;
                    bus.lsu_resp_err   = bus.s_resp_err;
                end else begin
                    bus.s_resp_ready   = bus.ifu_resp_ready;
                    bus.ifu_resp_valid = bus.s_resp_valid;
                    bus.ifu_rdata      = bus.s_rdata;
                    bus.ifu_resp_err   = bus.s_resp_err;
                end
                if (bus.s_resp_valid && bus.s_resp_ready) begin
                    stateNext = IDLE;
                end else if (timerExpired) begin
                    stateNext = ERR;
                end
            end
            ERR: begin
                if (owner == OWNER_LSU) begin
                    bus.lsu_resp_valid = 1'b1;
                    bus.lsu_resp_err   = RESP_ERR;
                    if (bus.lsu_resp_ready) begin
                        stateNext = IDLE;
                    end
                end else begin
                    bus.ifu_resp_valid = 1'b1;
                    bus.ifu_resp_err   = RESP_ERR;
                    if (bus.ifu_resp_ready) begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants, slave requests and responses
// are queued as stimulus is driven and compared when the DUT produces them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } SReqExp;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } RespExp;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    logic   expGrant[$];
    SReqExp expSReq[$];
    RespExp expIfuResp[$];
    RespExp expLsuResp[$];

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] slaveData(input logic [31:0] addr);
        if (addr == 32'h8000_0000) return 32'h0010_0073;
        return addr ^ 32'hA5A5_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic expectIfu(input logic [31:0] addr);
        expGrant.push_back(OWNER_IFU);
        expSReq.push_back('{addr: addr, we: 1'b0, wdata: 32'h0, wmask: 4'h0});
        expIfuResp.push_back('{rdata: slaveData(addr), err: 1'b0});
    endtask

    task automatic expectLsu(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [3:0] wmask, input logic withResp);
        expGrant.push_back(OWNER_LSU);
        expSReq.push_back('{addr: addr, we: we, wdata: wdata, wmask: wmask});
        if (withResp) expLsuResp.push_back('{rdata: slaveData(addr), err: 1'b0});
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues count back-to-back fetches, valid held high across them; returns 1ns after the last grant edge.
    task automatic applyIfuStimulus(input logic [31:0] base, input int count);
        int n;
        for (int k = 0; k < count; k++) begin
            bus.ifu_req_valid = 1'b1;
            bus.ifu_addr      = base + 32'(4 * k);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.ifu_req_ready && n < 100);
            checkOutput("ifuGrantWait", bus.ifu_req_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.ifu_req_valid = 1'b0;
    endtask

    task automatic applyLsuStimulus(input logic [31:0] base, input int count, input logic we,
                                    input logic [31:0] wdata, input logic [3:0] wmask);
        int n;
        for (int k = 0; k < count; k++) begin
            bus.lsu_req_valid = 1'b1;
            bus.lsu_addr      = base + 32'(4 * k);
            bus.lsu_we        = we;
            bus.lsu_wdata     = wdata + 32'(k);
            bus.lsu_wmask     = wmask;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.lsu_req_ready && n < 100);
            checkOutput("lsuGrantWait", bus.lsu_req_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic applyReset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Zero-wait memory: accepts whenever s_req_ready is high, answers the next cycle.
    initial begin : slaveModel
        logic        reqFire;
        logic        respFire;
        logic [31:0] addr;
        bus.s_resp_valid = 1'b0;
        bus.s_rdata      = '0;
        bus.s_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            reqFire  = bus.s_req_valid && bus.s_req_ready;
            respFire = bus.s_resp_valid && bus.s_resp_ready;
            addr     = bus.s_addr;
            @(posedge clk);
            #1;
            if (!rst || respFire) begin
                bus.s_resp_valid = 1'b0;
            end else if (reqFire) begin
                bus.s_resp_valid = 1'b1;
                bus.s_rdata      = slaveData(addr);
                bus.s_resp_err   = 1'b0;
            end
        end
    end

    initial begin : monitor
        SReqExp sr;
        RespExp rr;
        forever begin
            @(negedge clk);
            if (bus.ifu_req_ready) begin
                if (expGrant.size() == 0) checkOutput("ifuGrantUnexpected", 1'b1, 1'b0);
                else checkOutput("grantOwnerIfu", OWNER_IFU, expGrant.pop_front());
            end
            if (bus.lsu_req_ready) begin
                if (expGrant.size() == 0) checkOutput("lsuGrantUnexpected", 1'b1, 1'b0);
                else checkOutput("grantOwnerLsu", OWNER_LSU, expGrant.pop_front());
            end
            if (bus.s_req_valid && bus.s_req_ready) begin
                if (expSReq.size() == 0) begin
                    checkOutput("sReqUnexpected", 1'b1, 1'b0);
                end else begin
                    sr = expSReq.pop_front();
                    checkOutput("sAddr", bus.s_addr, sr.addr);
                    checkOutput("sWe", bus.s_we, sr.we);
                    checkOutput("sWdata", bus.s_wdata, sr.wdata);
                    checkOutput("sWmask", bus.s_wmask, sr.wmask);
                end
            end
            if (bus.ifu_resp_valid && bus.ifu_resp_ready) begin
                if (expIfuResp.size() == 0) begin
                    checkOutput("ifuRespUnexpected", 1'b1, 1'b0);
                end else begin
                    rr = expIfuResp.pop_front();
                    checkOutput("ifuRdata", bus.ifu_rdata, rr.rdata);
                    checkOutput("ifuErr", bus.ifu_resp_err, rr.err);
                end
            end
            if (bus.lsu_resp_valid && bus.lsu_resp_ready) begin
                if (expLsuResp.size() == 0) begin
                    checkOutput("lsuRespUnexpected", 1'b1, 1'b0);
                end else begin
                    rr = expLsuResp.pop_front();
                    checkOutput("lsuRdata", bus.lsu_rdata, rr.rdata);
                    checkOutput("lsuErr", bus.lsu_resp_err, rr.err);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : mainSequence
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 32'h1234_5678;
        bus.ifu_resp_ready = 1'b1;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_addr       = 32'h8765_4321;
        bus.lsu_we         = 1'b1;
        bus.lsu_wdata      = 32'hFFFF_FFFF;
        bus.lsu_wmask      = 4'hF;
        bus.lsu_resp_ready = 1'b1;
        bus.s_req_ready    = 1'b1;

        // Requests are valid while reset is held: nothing may be accepted.
        @(negedge clk);
        checkOutput("rstIfuReqReady", bus.ifu_req_ready, 1'b0);
        checkOutput("rstLsuReqReady", bus.lsu_req_ready, 1'b0);
        checkOutput("rstSReqValid", bus.s_req_valid, 1'b0);
        checkOutput("rstSRespReady", bus.s_resp_ready, 1'b0);
        checkOutput("rstIfuRespValid", bus.ifu_resp_valid, 1'b0);
        checkOutput("rstLsuRespValid", bus.lsu_resp_valid, 1'b0);
        checkOutput("rstSAddr", bus.s_addr, 32'h0);
        checkOutput("rstSWe", bus.s_we, 1'b0);
        checkOutput("rstSWdata", bus.s_wdata, 32'h0);
        checkOutput("rstSWmask", bus.s_wmask, 4'h0);
        checkOutput("rstIfuRdata", bus.ifu_rdata, 32'h0);
        checkOutput("rstLsuErr", bus.lsu_resp_err, 1'b0);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] single fetch latency");
        expectIfu(32'h8000_0000);
        applyIfuStimulus(32'h8000_0000, 1);
        @(negedge clk);
        checkOutput("fetchSReqValid", bus.s_req_valid, 1'b1);
        checkOutput("fetchSAddr", bus.s_addr, 32'h8000_0000);
        checkOutput("fetchSWe", bus.s_we, 1'b0);
        checkOutput("fetchReqReadyBusy", bus.ifu_req_ready, 1'b0);
        @(negedge clk);
        checkOutput("fetchRespValid", bus.ifu_resp_valid, 1'b1);
        checkOutput("fetchRdata", bus.ifu_rdata, 32'h0010_0073);
        checkOutput("fetchErr", bus.ifu_resp_err, 1'b0);
        checkOutput("fetchLsuRespValid", bus.lsu_resp_valid, 1'b0);
        @(negedge clk);
        checkOutput("fetchIdleSReq", bus.s_req_valid, 1'b0);
        checkOutput("fetchIdleResp", bus.ifu_resp_valid, 1'b0);

        $display("[TB] simultaneous requests from reset");
        applyReset();
        expectIfu(32'h8000_0004);
        expectLsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b1);
        fork
            applyIfuStimulus(32'h8000_0004, 1);
            applyLsuStimulus(32'h8000_1000, 1, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        join
        idleCycles(4);

        $display("[TB] alternating grants with both requesters held");
        for (int k = 0; k < 3; k++) begin
            expectIfu(32'h8000_0010 + 32'(4 * k));
            expectLsu(32'h8000_3000 + 32'(4 * k), 1'b1, 32'h0000_5000 + 32'(k), 4'h0, 1'b1);
        end
        fork
            applyIfuStimulus(32'h8000_0010, 3);
            applyLsuStimulus(32'h8000_3000, 3, 1'b1, 32'h0000_5000, 4'h0);
        join
        idleCycles(4);

        $display("[TB] request phase timeout");
        bus.s_req_ready = 1'b0;
        expGrant.push_back(OWNER_IFU);
        expIfuResp.push_back('{rdata: 32'h0, err: 1'b1});
        applyIfuStimulus(32'h8000_0100, 1);
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            checkOutput("toReqHeld", bus.s_req_valid, 1'b1);
            checkOutput("toNoRespYet", bus.ifu_resp_valid, 1'b0);
        end
        @(negedge clk);
        checkOutput("toErrValid", bus.ifu_resp_valid, 1'b1);
        checkOutput("toErrFlag", bus.ifu_resp_err, 1'b1);
        checkOutput("toErrRdata", bus.ifu_rdata, 32'h0);
        checkOutput("toErrSReq", bus.s_req_valid, 1'b0);
        checkOutput("toErrSRespReady", bus.s_resp_ready, 1'b0);
        @(negedge clk);
        checkOutput("toBackIdle", bus.ifu_resp_valid, 1'b0);
        bus.s_req_ready = 1'b1;
        idleCycles(2);

        $display("[TB] LSU response back-pressure");
        bus.lsu_resp_ready = 1'b0;
        expectLsu(32'h8000_2000, 1'b0, 32'h0, 4'h0, 1'b1);
        expectIfu(32'h8000_0200);
        applyLsuStimulus(32'h8000_2000, 1, 1'b0, 32'h0, 4'h0);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0200;
        @(negedge clk);
        checkOutput("bpSReqValid", bus.s_req_valid, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("bpLsuRespValid", bus.lsu_resp_valid, 1'b1);
            checkOutput("bpSRespReady", bus.s_resp_ready, 1'b0);
            checkOutput("bpLsuRdata", bus.lsu_rdata, slaveData(32'h8000_2000));
            checkOutput("bpIfuStalled", bus.ifu_req_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.lsu_resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpHandshake", bus.s_resp_ready, 1'b1);
        @(negedge clk);
        checkOutput("bpIfuGranted", bus.ifu_req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.ifu_req_valid = 1'b0;
        idleCycles(4);

        $display("[TB] reset during response phase");
        bus.lsu_resp_ready = 1'b0;
        expectLsu(32'h8000_4000, 1'b1, 32'hCAFE_F00D, 4'b1100, 1'b0);
        applyLsuStimulus(32'h8000_4000, 1, 1'b1, 32'hCAFE_F00D, 4'b1100);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mrInResp", bus.lsu_resp_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mrLsuRespValid", bus.lsu_resp_valid, 1'b0);
        checkOutput("mrSRespReady", bus.s_resp_ready, 1'b0);
        checkOutput("mrSReqValid", bus.s_req_valid, 1'b0);
        checkOutput("mrSAddr", bus.s_addr, 32'h0);
        checkOutput("mrSWdata", bus.s_wdata, 32'h0);
        checkOutput("mrSWmask", bus.s_wmask, 4'h0);
        checkOutput("mrLsuRdata", bus.lsu_rdata, 32'h0);
        bus.lsu_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("mrNoIfuResp", bus.ifu_resp_valid, 1'b0);
            checkOutput("mrNoLsuResp", bus.lsu_resp_valid, 1'b0);
        end

        checkOutput("grantQueueDrained", 64'(expGrant.size()), 64'd0);
        checkOutput("sReqQueueDrained", 64'(expSReq.size()), 64'd0);
        checkOutput("ifuRespQueueDrained", 64'(expIfuResp.size()), 64'd0);
        checkOutput("lsuRespQueueDrained", 64'(expLsuResp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one simple valid/ready memory port between the IFU (instruction fetch, read-only) and the LSU (the load/store path fed by the decode/execute stage).
- Holds at most one outstanding transaction.
- Arbitrates ties round-robin and latches the winning request.
- Routes the single response back to its owner; a stuck slave is converted into an error response by a timeout counter.

Parameters:
AW, 32, address width
DW, 32, data width; write mask width is DW/8
TIMEOUT, 255, cycles allowed per phase (REQ or RESP) before abort; 0 disables the timeout

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset (asserted when 0)
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  AW  fetch address
ifu_resp_valid  out  1  fetch response valid
ifu_resp_ready  in  1  IFU takes response
ifu_rdata  out  DW  fetched instruction
ifu_resp_err  out  1  slave error or timeout
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  AW  load/store address
lsu_we  in  1  1 = store
lsu_wdata  in  DW  store data
lsu_wmask  in  DW/8  byte enables
lsu_resp_valid  out  1  LSU response valid
lsu_resp_ready  in  1  LSU takes response
lsu_rdata  out  DW  load data (unextended)
lsu_resp_err  out  1  slave error or timeout
s_req_valid  out  1  request to memory
s_req_ready  in  1  memory accepts request
s_addr  out  AW  latched address
s_we  out  1  latched write enable
s_wdata  out  DW  latched write data
s_wmask  out  DW/8  latched mask
s_resp_valid  in  1  memory response
s_resp_ready  out  1  arbiter accepts response
s_rdata  in  DW  read data
s_resp_err  in  1  memory error

Behaviour:
- Reset state and values:
  - state=IDLE, owner=IFU, last_grant=LSU, so the IFU wins the first tie.
  - Timer=0; holding registers (addr, we, wdata, wmask) = 0.
  - All *_valid and *_ready outputs = 0; rdata outputs = 0; err outputs = 0.
- States: IDLE, REQ, RESP, ERR (2-bit encoding).
- IDLE:
  - Winner selection:
    - Only one requester valid: that requester wins.
    - Both valid: the one that is not last_grant wins.
  - Winner's *_req_ready=1 combinationally; the loser's is 0.
  - On the handshake, latch the request:
    - Latch addr, we (forced 0 for IFU), wdata and wmask (forced 0 for IFU).
    - Set owner=last_grant=winner, timer=0, go to REQ.
  - No requester valid: stay in IDLE.
- REQ:
  - s_req_valid=1; s_* driven from the holding registers and stable until the handshake.
  - On s_req_ready: timer=0, go to RESP.
  - Otherwise timer increments; when timer==TIMEOUT-1 (TIMEOUT≠0), go to ERR.
- RESP:
  - s_resp_ready = owner's resp_ready.
  - Owner sees resp_valid=s_resp_valid, rdata=s_rdata, err=s_resp_err combinationally.
  - The non-owner's resp_valid is 0.
  - When s_resp_valid and s_resp_ready are both 1: go to IDLE.
  - A timer runs as in REQ; on expiry, go to ERR.
- ERR:
  - Owner sees resp_valid=1, err=1, rdata=0; s_req_valid=0 and s_resp_ready=0.
  - On the owner's resp_ready: go to IDLE.
- Latency: grant in cycle N; s_req_valid is high in N+1. With a zero-wait slave (response the cycle after acceptance), the owner's response is in N+2 and IDLE is re-entered in N+3.
- In any state other than IDLE, both *_req_ready=0.
- A requester may drop valid before grant; nothing is latched.
- s_resp_valid in IDLE or REQ is ignored (s_resp_ready=0).
- A store with wmask=0 is forwarded unchanged.
- Reset mid-transaction: immediate return to the reset values; the outstanding transaction is dropped and no response is issued.
- The timer is DW-independent, $clog2(TIMEOUT+1) bits, and saturates rather than wrapping.

Decomposition:
- Shared package: state enum (IDLE/REQ/RESP/ERR), owner constants (OWNER_IFU=0, OWNER_LSU=1), response-error encoding.
- One sub-module is natural: rr_pick2, a combinational two-way round-robin selector with inputs (req[1:0], last) and outputs (gnt[1:0]).

Test Plan:
- Single IFU fetch, addr=0x80000000, slave zero-wait returns 0x00100073:
  - ifu_req_ready in cycle N; s_req_valid with s_addr=0x80000000, s_we=0 in N+1.
  - ifu_resp_valid with rdata=0x00100073, err=0 in N+2.
- Simultaneous IFU(0x80000004) and LSU store (0x80001000, wdata=0xDEADBEEF, wmask=4'b0011) from reset:
  - IFU is served first, then LSU.
  - s_wmask=0011 and s_wdata=0xDEADBEEF on the LSU grant.
- Both requesters held continuously for 6 transactions -> grants alternate IFU, LSU, IFU, LSU, IFU, LSU.
- Slave holds s_req_ready=0 with TIMEOUT=4 -> ERR after 4 REQ cycles; owner gets resp_valid=1, err=1, rdata=0, then IDLE.
- LSU load, slave responds but lsu_resp_ready is low for 3 cycles:
  - s_resp_ready stays 0 and lsu_rdata remains valid.
  - The handshake completes on the 4th cycle; the IFU request is stalled meanwhile.
- rst pulled low during RESP -> outputs go to reset values asynchronously; no resp_valid on either master after rst returns to 1.
